// File: rtl/pong_game_ctrl.sv
// rtl/pong_game_ctrl.sv - pong game sequencing: serve, scoring, lives and game-over hold
module pong_game_ctrl #(
    parameter int BALLS       = 3,
    parameter int SERVE_TICKS = 120
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic [1:0] btn1,
    input  logic [1:0] btn2,
    input  logic       hit_left,
    input  logic       hit_right,
    input  logic       miss,
    output logic       graph_still,
    output logic [1:0] game_state,
    output logic [7:0] score_left,
    output logic [7:0] score_right,
    output logic [1:0] balls_left,
    output logic       game_over
);

    localparam logic [1:0] NEWGAME = 2'd0;
    localparam logic [1:0] PLAY    = 2'd1;
    localparam logic [1:0] NEWBALL = 2'd2;
    localparam logic [1:0] OVER    = 2'd3;

    localparam logic [1:0] BALLS_INIT = BALLS[1:0];
    localparam logic [7:0] SERVE_INIT = SERVE_TICKS[7:0];

    logic [1:0] state;
    logic [1:0] state_next;
    logic [7:0] timer;
    logic       hit_left_q;
    logic       hit_right_q;
    logic       any_btn;
    logic       timer_zero;
    logic       hit_left_rise;
    logic       hit_right_rise;
    logic       play_miss;

    assign any_btn        = |(btn1 | btn2);
    assign timer_zero     = (timer == 8'd0);
    assign hit_left_rise  = hit_left & ~hit_left_q;
    assign hit_right_rise = hit_right & ~hit_right_q;
    assign play_miss      = (state == PLAY) && miss;
    assign game_state     = state;

    // Two-digit BCD increment that sticks at 99.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [7:0] r;
        if (v == 8'h99) begin
            r = v;
        end else if (v[3:0] == 4'd9) begin
            r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    always_comb begin
        state_next = state;
        case (state)
            NEWGAME: if (any_btn) state_next = PLAY;
            PLAY: begin
                if (miss) state_next = (balls_left == 2'd1) ? OVER : NEWBALL;
            end
            NEWBALL: if (timer_zero && !any_btn) state_next = PLAY;
            OVER: if (timer_zero) state_next = NEWGAME;
            default: state_next = NEWGAME;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= NEWGAME;
            graph_still <= 1'b1;
            game_over   <= 1'b0;
        end else begin
            state       <= state_next;
            graph_still <= (state_next != PLAY);
            game_over   <= play_miss && (balls_left == 2'd1);
        end
    end

    // Reload on a miss wins over the frame-tick countdown.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer <= 8'd0;
        end else if (play_miss) begin
            timer <= SERVE_INIT;
        end else if (frame_tick && !timer_zero) begin
            timer <= timer - 8'd1;
        end
    end

    // Edge registers follow the hit inputs in every state so a paddle
    // already overlapping at serve does not score a phantom hit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_left_q  <= 1'b0;
            hit_right_q <= 1'b0;
        end else begin
            hit_left_q  <= hit_left;
            hit_right_q <= hit_right;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            score_left  <= 8'h00;
            score_right <= 8'h00;
            balls_left  <= BALLS_INIT;
        end else begin
            case (state)
                NEWGAME: begin
                    score_left  <= 8'h00;
                    score_right <= 8'h00;
                    balls_left  <= BALLS_INIT;
                end
                PLAY: begin
                    if (miss) begin
                        balls_left <= balls_left - 2'd1;
                    end else begin
                        if (hit_left_rise)  score_left  <= bcd_inc(score_left);
                        if (hit_right_rise) score_right <= bcd_inc(score_right);
                    end
                end
                OVER: begin
                    if (timer_zero) begin
                        score_left  <= 8'h00;
                        score_right <= 8'h00;
                        balls_left  <= BALLS_INIT;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// tb/tb_pong_game_ctrl.sv - directed and randomized bench against a behavioural game model
module tb_pong_game_ctrl;

    localparam int BALLS_N = 3;
    localparam int SERVE_N = 120;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       frame_tick = 1'b0;
    logic [1:0] btn1 = 2'b00;
    logic [1:0] btn2 = 2'b00;
    logic       hit_left = 1'b0;
    logic       hit_right = 1'b0;
    logic       miss = 1'b0;
    logic       graph_still;
    logic [1:0] game_state;
    logic [7:0] score_left;
    logic [7:0] score_right;
    logic [1:0] balls_left;
    logic       game_over;

    pong_game_ctrl #(.BALLS(BALLS_N), .SERVE_TICKS(SERVE_N)) dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick),
        .btn1(btn1), .btn2(btn2),
        .hit_left(hit_left), .hit_right(hit_right), .miss(miss),
        .graph_still(graph_still), .game_state(game_state),
        .score_left(score_left), .score_right(score_right),
        .balls_left(balls_left), .game_over(game_over)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: scores as plain decimal counts, phase as a small integer.
    int m_phase;   // 0 waiting, 1 rally, 2 serve, 3 over
    int m_left, m_right, m_balls, m_timer;
    bit m_prev_l, m_prev_r, m_over_pulse;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] to_bcd(input int n);
        logic [7:0] r;
        r = 8'((n / 10) * 16 + (n % 10));
        return r;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_left = 0; m_right = 0; m_balls = BALLS_N; m_timer = 0;
        m_prev_l = 0; m_prev_r = 0; m_over_pulse = 0;
    endtask

    task automatic model_clock(input logic [1:0] b1, input logic [1:0] b2,
                               input bit hl, input bit hr, input bit ms, input bit ft);
        int  t0;
        bit  pressed;
        t0 = m_timer;
        pressed = (b1 != 0) || (b2 != 0);
        m_over_pulse = 0;
        if (m_phase == 1 && ms) m_timer = SERVE_N;
        else if (ft && m_timer > 0) m_timer = m_timer - 1;
        case (m_phase)
            0: begin
                m_left = 0; m_right = 0; m_balls = BALLS_N;
                if (pressed) m_phase = 1;
            end
            1: begin
                if (ms) begin
                    if (m_balls == 1) begin m_phase = 3; m_over_pulse = 1; end
                    else m_phase = 2;
                    m_balls = m_balls - 1;
                end else begin
                    if (hl && !m_prev_l && m_left < 99) m_left = m_left + 1;
                    if (hr && !m_prev_r && m_right < 99) m_right = m_right + 1;
                end
            end
            2: if (t0 == 0 && !pressed) m_phase = 1;
            default: if (t0 == 0) begin
                m_phase = 0; m_left = 0; m_right = 0; m_balls = BALLS_N;
            end
        endcase
        m_prev_l = hl;
        m_prev_r = hr;
    endtask

    task automatic compare_all();
        check("game_state", 32'(game_state), 32'(m_phase));
        check("graph_still", 32'(graph_still), (m_phase == 1) ? 32'd0 : 32'd1);
        check("score_left", 32'(score_left), 32'(to_bcd(m_left)));
        check("score_right", 32'(score_right), 32'(to_bcd(m_right)));
        check("balls_left", 32'(balls_left), 32'(m_balls));
        check("game_over", 32'(game_over), 32'(m_over_pulse));
    endtask

    task automatic step(input logic [1:0] b1, input logic [1:0] b2,
                        input logic hl, input logic hr, input logic ms, input logic ft);
        btn1 = b1; btn2 = b2; hit_left = hl; hit_right = hr; miss = ms; frame_tick = ft;
        @(posedge clk);
        model_clock(b1, b2, hl, hr, ms, ft);
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Reset asserted between clock edges; outputs must react before the next edge.
    task automatic async_reset();
        btn1 = 0; btn2 = 0; hit_left = 0; hit_right = 0; miss = 0; frame_tick = 0;
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check("rst_state", 32'(game_state), 32'd0);
        check("rst_still", 32'(graph_still), 32'd1);
        check("rst_balls", 32'(balls_left), 32'(BALLS_N));
        check("rst_scores", {16'd0, score_left, score_right}, 32'd0);
        check("rst_over", 32'(game_over), 32'd0);
        @(posedge clk);
        #1;
        compare_all();
        #2;
        reset = 1'b0;
    endtask

    task automatic wait_phase(input string tag, input int phase, input bit ft, input int limit);
        int n;
        n = 0;
        while (m_phase != phase && n < limit) begin
            step(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, ft);
            n++;
        end
        check(tag, 32'(game_state), 32'(phase));
    endtask

    initial begin
        logic hl_r, hr_r;
        model_reset();
        #1 reset = 1'b1;
        #1;
        check("init_state", 32'(game_state), 32'd0);
        check("init_balls", 32'(balls_left), 32'd3);
        @(posedge clk);
        #3 reset = 1'b0;

        // Nothing happens without a button
        idle(5);
        check("wait_newgame", 32'(game_state), 32'd0);

        step(2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
        check("start_play", 32'(game_state), 32'd1);
        check("start_still", 32'(graph_still), 32'd0);

        // One long overlap counts once
        for (int i = 0; i < 500; i++) step(2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
        step(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        check("long_hit", 32'(score_left), 32'h01);

        for (int i = 0; i < 10; i++) begin
            step(2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
            step(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        check("bcd_carry", 32'(score_right), 32'h10);
        for (int i = 0; i < 99; i++) begin
            step(2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
            step(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        check("bcd_sat", 32'(score_right), 32'h99);

        // Serve delay with a held button
        step(2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
        check("miss_balls", 32'(balls_left), 32'd2);
        check("miss_state", 32'(game_state), 32'd2);
        check("miss_still", 32'(graph_still), 32'd1);
        for (int i = 0; i < 125; i++) step(2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
        check("held_btn", 32'(game_state), 32'd2);
        step(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        check("release_play", 32'(game_state), 32'd1);

        // Miss beats a simultaneous hit
        step(2'b00, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0);
        check("prio_score", 32'(score_left), 32'h01);
        check("prio_balls", 32'(balls_left), 32'd1);
        step(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_phase("serve2", 1, 1'b1, 300);

        // Last ball
        step(2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
        check("over_pulse", 32'(game_over), 32'd1);
        check("over_state", 32'(game_state), 32'd3);
        step(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
        check("over_pulse_end", 32'(game_over), 32'd0);
        wait_phase("over_done", 0, 1'b1, 300);
        check("new_scores", {16'd0, score_left, score_right}, 32'd0);
        check("new_balls", 32'(balls_left), 32'd3);

        // Reset in the middle of a serve countdown
        step(2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        step(2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
        step(2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 200 && m_timer != 60; i++) step(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
        check("timer_at_60", 32'(m_timer), 32'd60);
        async_reset();
        idle(10);
        check("post_rst_wait", 32'(game_state), 32'd0);

        // Randomized play against the model
        hl_r = 0; hr_r = 0;
        for (int i = 0; i < 4000; i++) begin
            logic [1:0] b1, b2;
            if ($urandom_range(0, 5) == 0) hl_r = ~hl_r;
            if ($urandom_range(0, 5) == 0) hr_r = ~hr_r;
            b1 = ($urandom_range(0, 11) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            b2 = ($urandom_range(0, 11) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            step(b1, b2, hl_r, hr_r, 1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 1)));
            if (i == 2000) async_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pong_game_ctrl.md
PONG_GAME_CTRL -- requirements
Module: pong_game_ctrl

Interface
REQ-001 Parameter BALLS, default 3, SHALL set the number of balls (lives) per game, range 1..3.
REQ-002 Parameter SERVE_TICKS, default 120, SHALL set the serve and game-over hold time in frame ticks, range 1..255.
REQ-003 Port clk, input, 1 bit: system clock; all state changes SHALL occur on its rising edge.
REQ-004 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port frame_tick, input, 1 bit: one-clk pulse at the start of each vertical sync (60 Hz).
REQ-006 Port btn1, input, 2 bits: right-paddle buttons, {down, up}.
REQ-007 Port btn2, input, 2 bits: left-paddle buttons, {down, up}.
REQ-008 Port hit_left, input, 1 bit: level, high while the ball overlaps the left paddle.
REQ-009 Port hit_right, input, 1 bit: level, high while the ball overlaps the right paddle.
REQ-010 Port miss, input, 1 bit: level, high while the ball is past either goal line.
REQ-011 Port graph_still, output, 1 bit: registered; high holds the ball and paddles at centre.
REQ-012 Port game_state, output, 2 bits: registered; 0=NEWGAME, 1=PLAY, 2=NEWBALL, 3=OVER.
REQ-013 Port score_left, output, 8 bits: two-digit BCD left-player hit count, {tens, units}.
REQ-014 Port score_right, output, 8 bits: two-digit BCD right-player hit count, {tens, units}.
REQ-015 Port balls_left, output, 2 bits: balls remaining in the current game.
REQ-016 Port game_over, output, 1 bit: one-clk pulse on entry to OVER.

Function
REQ-017 The state machine SHALL have exactly four states: NEWGAME, PLAY, NEWBALL and OVER.
REQ-018 graph_still SHALL be 0 in PLAY and 1 in all other states, registered with the state.
REQ-019 NEWGAME: scores SHALL be held at 0 and balls_left at BALLS.
REQ-020 NEWGAME -> PLAY SHALL occur on the first clk where (btn1 | btn2) != 0.
REQ-021 PLAY: a rising edge of hit_left (registered previous value was 0, current value is 1) SHALL increment score_left by 1, BCD.
REQ-022 PLAY: a rising edge of hit_right SHALL increment score_right by 1, BCD.
REQ-023 Each hit-input level pulse SHALL give at most one increment, regardless of pulse length.
REQ-024 BCD increment: units 9 -> 0 with a carry into tens; 99 SHALL saturate at 99.
REQ-025 PLAY: on a clk with miss=1, balls_left SHALL decrement by 1.
REQ-026 On that miss, if balls_left was 1: next state OVER, game_over=1 for one clk; otherwise: next state NEWBALL.
REQ-027 On that miss, the serve timer SHALL load SERVE_TICKS.
REQ-028 Miss SHALL take priority over a hit rising edge on the same clk: no score change on that clk.
REQ-029 Simultaneous hit_left and hit_right rising edges in PLAY SHALL increment both scores.
REQ-030 Serve timer: 8-bit down-counter, decremented only on a frame_tick while non-zero; it SHALL never wrap below 0.
REQ-031 NEWBALL -> PLAY SHALL occur when the timer is 0 and (btn1 | btn2) == 0; while any button is held, the block SHALL stay in NEWBALL.
REQ-032 OVER -> NEWGAME SHALL occur when the timer is 0; scores and balls_left SHALL be reset on entry to NEWGAME.
REQ-033 miss, hit_left and hit_right SHALL be ignored outside PLAY, and the edge registers SHALL still track their inputs there.
REQ-034 Scores SHALL be held at their values in NEWBALL and OVER.
REQ-035 The block SHALL be fully synchronous apart from reset and SHALL contain no combinational path from an input to an output.

Reset
REQ-036 While reset=1: state=NEWGAME, graph_still=1, game_state=0, score_left=0, score_right=0, balls_left=BALLS, game_over=0, timer=0, hit edge registers=0.
REQ-037 Assertion of reset at any point, including mid-timer or mid-PLAY, SHALL take effect immediately without waiting for clk.
REQ-038 After reset release, the first state change SHALL require a button press.

Verification
REQ-039 Start game and score: reset, btn2=01 for 1 clk -> game_state=1 and graph_still=0 next clk; hit_left high for 500 clks -> score_left=0x01 only.
REQ-040 BCD carry: 10 separate hit_right pulses -> score_right=0x10; 99 further pulses -> score_right=0x99 (saturated).
REQ-041 Serve delay: miss in PLAY -> balls_left 3->2, state NEWBALL, graph_still=1; button held after 120 frame_ticks -> still NEWBALL; button released -> PLAY next clk.
REQ-042 Game over: three misses (BALLS=3) -> game_over pulses once for 1 clk, state OVER; after 120 frame_ticks -> NEWGAME with scores 0x00 and balls_left=3.
REQ-043 Priority: miss and hit_left rise on the same clk -> score_left unchanged and balls_left decremented.
REQ-044 Reset mid-NEWBALL with timer=60 -> all outputs take their reset values asynchronously; after release, state stays NEWGAME until a button press.
